// File: rtl/seg_scanner.sv
// Multiplexed seven-segment scanner: walks DIGITS anodes at SCAN_DIV clocks per slot,
// showing a frame-latched snapshot of the inputs with optional leading-zero suppression.
module seg_scanner #(
    parameter int DIGITS        = 4,
    parameter int SCAN_DIV      = 25000,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   num,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_en,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0]     CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_MAX = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACTIVE_LOW != 0}};

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic                tick;
    logic                wrap;

    logic [4*DIGITS-1:0] sh_num;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blank;
    logic                sh_lz;

    logic [DIGITS-1:0]   sup;
    logic [DIGITS-1:0]   an_act;
    logic [3:0]          cur_nib;
    logic                cur_off;
    logic                cur_dp;
    logic [6:0]          glyph;

    assign tick = (cnt == CNT_MAX);
    assign wrap = tick && (idx == IDX_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + 1'b1;
            frame_tick <= wrap;
            if (tick) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end
        end
    end

    // Snapshot at frame wrap so mid-frame input changes never tear the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_num   <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            sh_lz    <= 1'b0;
        end else if (wrap) begin
            sh_num   <= num;
            sh_dp    <= dp_in;
            sh_blank <= blank;
            sh_lz    <= lz_en;
        end
    end

    // Suppression scans from the most significant digit down, tracking "all zero so far".
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        sup      = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            int unsigned d;
            d        = DIGITS - 1 - k;
            all_zero = all_zero & (sh_num[4*d +: 4] == 4'd0);
            sup[d]   = sh_lz && (d != 0) && all_zero;
        end
    end

    always_comb begin
        cur_nib = '0;
        cur_off = 1'b1;
        cur_dp  = 1'b0;
        an_act  = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib   = sh_num[4*k +: 4];
                cur_off   = sh_blank[k] | sup[k];
                cur_dp    = sh_dp[k];
                an_act[k] = ~(sh_blank[k] | sup[k]);
            end
        end
    end

    always_comb begin
        glyph = 7'b1111111;
        unique case (cur_nib)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= '1;
            dp  <= 1'b1;
        end else begin
            an  <= an_act ^ AN_OFF;
            seg <= cur_off ? 7'b1111111 : glyph;
            dp  <= cur_off ? 1'b1 : ~cur_dp;
        end
    end

endmodule

// File: tb/tb_seg_scanner.sv
// Bench for seg_scanner (DIGITS=4, SCAN_DIV=4): a timeline model predicts every output
// cycle from the edge count since reset release and the frame-latched inputs.
module tb_seg_scanner;

    localparam int D = 4;
    localparam int S = 4;
    localparam int FRAME = D * S;

    logic        clk;
    logic        rst_n;
    logic [15:0] num;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic        lz_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    seg_scanner #(.DIGITS(D), .SCAN_DIV(S), .AN_ACTIVE_LOW(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .num        (num),
        .dp_in      (dp_in),
        .blank      (blank),
        .lz_en      (lz_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [6:0] glyphs [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Model state: edges since reset release and the inputs latched at the last wrap.
    int          n;
    logic [15:0] m_num;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;
    logic        m_lz;
    int          ft_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s @n=%0d: got %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    task automatic step();
        int          d;
        logic [15:0] upper;
        logic        off;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        e_ft;
        @(posedge clk);
        n++;
        d     = ((n - 1) / S) % D;
        upper = m_num >> (4 * d);
        off   = m_blank[d] || (m_lz && d > 0 && upper == 16'd0);
        e_an  = off ? 4'b1111 : ~(4'b0001 << d);
        e_seg = off ? 7'b1111111 : glyphs[upper[3:0]];
        e_dp  = off ? 1'b1 : ~m_dp[d];
        e_ft  = (n % FRAME) == 0;
        if (e_ft) begin
            m_num   = num;
            m_dp    = dp_in;
            m_blank = blank;
            m_lz    = lz_en;
        end
        @(negedge clk);
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("frame_tick", 32'(frame_tick), 32'(e_ft));
        if (frame_tick) ft_seen++;
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_an"}, 32'(an), 32'hF);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_dp"}, 32'(dp), 32'h1);
        check({tag, "_ft"}, 32'(frame_tick), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 reset_values("rst_now");
        repeat (2) begin
            @(negedge clk);
            reset_values("rst_hold");
        end
        rst_n   = 1'b1;
        n       = 0;
        m_num   = '0;
        m_dp    = '0;
        m_blank = '0;
        m_lz    = 1'b0;
        ft_seen = 0;
    endtask

    task automatic phase(input logic [15:0] p_num, input logic [3:0] p_dp,
                         input logic [3:0] p_blank, input logic p_lz, input int cycles);
        num   = p_num;
        dp_in = p_dp;
        blank = p_blank;
        lz_en = p_lz;
        repeat (cycles) step();
    endtask

    initial begin
        rst_n = 1'b0;
        num   = '0;
        dp_in = '0;
        blank = '0;
        lz_en = 1'b0;
        n     = 0;
        do_reset();

        phase(16'h12AF, 4'b0000, 4'b0000, 1'b0, 48);
        phase(16'h0050, 4'b0000, 4'b0000, 1'b1, 40);
        phase(16'h0000, 4'b0000, 4'b0000, 1'b1, 40);
        phase(16'h1111, 4'b0000, 4'b0000, 1'b0, 30);
        phase(16'h2222, 4'b0000, 4'b0000, 1'b0, 40);
        phase(16'h3C4D, 4'b0001, 4'b0100, 1'b0, 40);

        phase(16'h9876, 4'b1010, 4'b0000, 1'b0, 22);
        do_reset();

        // Free run with inputs scrambled at random points, including mid-frame.
        for (int i = 0; i < 100 * FRAME; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                num   = 16'($urandom);
                if ($urandom_range(0, 2) == 0) num = num & 16'h00FF;
                dp_in = 4'($urandom);
                blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
                lz_en = 1'($urandom);
            end
            step();
        end
        check("ft_count", 32'(ft_seen), 32'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scanner.md
SEG_SCANNER -- requirements
Module: seg_scanner

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits, legal range 1..16.
REQ-002 SHALL have parameter SCAN_DIV, default 25000: clk cycles per digit slot, legal range >=1.
REQ-003 SHALL have parameter AN_ACTIVE_LOW, default 1: anode polarity (1 = active-low, 0 = active-high).
REQ-004 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port num  input  4*DIGITS  hex nibbles; nibble i (num[4i+3:4i]) drives digit i, and digit 0 is rightmost.
REQ-007 SHALL have port dp_in  input  DIGITS  per-digit decimal point request, 1 = lit.
REQ-008 SHALL have port blank  input  DIGITS  per-digit force-off, 1 = blanked.
REQ-009 SHALL have port lz_en  input  1  leading-zero suppression enable.
REQ-010 SHALL have port an  output  DIGITS  anode enables, polarity set by AN_ACTIVE_LOW.
REQ-011 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 SHALL have port dp  output  1  decimal point, active-low.
REQ-013 SHALL have port frame_tick  output  1  one-cycle pulse at each frame wrap.

Function
REQ-014 SHALL run prescaler cnt from 0 to SCAN_DIV-1 and then wrap to 0; slot tick SHALL be asserted when cnt == SCAN_DIV-1, so SCAN_DIV=1 ticks every cycle.
REQ-015 SHALL advance digit index idx by 1 on each tick, wrapping from DIGITS-1 to 0 (DIGITS=1: idx stays 0).
REQ-016 SHALL, on the tick where idx == DIGITS-1 (the wrap), in the same edge: load shadow registers from num, dp_in, blank and lz_en; and set frame_tick=1 for exactly the next cycle.
REQ-017 SHALL drive the display only from shadow values; input changes mid-frame SHALL NOT affect outputs until after the next wrap (no tearing).
REQ-018 SHALL register an, seg and dp each cycle from the current idx and shadow values, giving one clk of latency after an idx or shadow change.
REQ-019 SHALL treat digit i as suppressed when shadow lz_en=1, i>0, and shadow nibbles i..DIGITS-1 are all zero; digit 0 SHALL never be suppressed.
REQ-020 SHALL, for a blanked or suppressed digit, make the anode inactive, set seg=1111111 and set dp=1.
REQ-021 SHALL, otherwise, make only an[idx] active and drive dp = ~shadow dp_in[idx].
REQ-022 SHALL decode seg using the following table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-023 SHALL make the frame period exactly DIGITS*SCAN_DIV cycles, with the first frame_tick occurring DIGITS*SCAN_DIV cycles after rst_n deasserts.
REQ-024 SHALL implement all counters with widths sized by $clog2 of their parameter (minimum 1 bit) and SHALL NOT overflow.

Reset
REQ-025 SHALL, on rst_n=0, immediately and asynchronously set cnt=0, idx=0, all shadow registers=0, frame_tick=0, every anode inactive, seg=1111111 and dp=1.
REQ-026 SHALL, after rst_n deasserts, display shadow zero (digit 0 shows "0" from the second cycle) until the first wrap loads live inputs.
REQ-027 SHALL, when reset is asserted mid-frame, abort the frame with no frame_tick, and scanning SHALL restart at idx=0.

Verification (DIGITS=4, SCAN_DIV=4, AN_ACTIVE_LOW=1)
REQ-028 SHALL cover: rst_n low mid-slot -> same-cycle an=1111, seg=1111111, dp=1, frame_tick=0.
REQ-029 SHALL cover: num=12AF, blank=0, lz_en=0, after first frame_tick -> 4-cycle slots in sequence an=1110/seg=0001110, 1101/0001000, 1011/0100100, 0111/1111001, repeating.
REQ-030 SHALL cover: lz_en=1, num=0050 -> digits 3 and 2 show an=1111; digit 1 shows seg=0010010; digit 0 shows 1000000; with num=0000 only digit 0 lights with "0".
REQ-031 SHALL cover: num changed from 1111 to 2222 mid-frame -> outputs keep showing "1" until the cycle after the next frame_tick, then show "2".
REQ-032 SHALL cover: blank=0100, dp_in=0001 -> digit 2 slot shows an=1111, seg=1111111; digit 0 slot shows dp=0; all others show dp=1.
REQ-033 SHALL cover: free run of 100 frames -> frame_tick high exactly 1 cycle every 16 cycles, and exactly one anode is active per slot, except in blanked or suppressed slots.
